// File: rtl/fsync_pkg.sv
// Shared definitions for the serial frame-synchronization controller:
// FSM state encoding and the default sync / loss-of-sync words.
package fsync_pkg;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_SYNCED = 1'b1
   } fsync_state_e;

   localparam logic [4:0] SECUENCIA_DEF    = 5'b10100;
   localparam logic [4:0] SEC_REINICIO_DEF = 5'b00000;

endpackage

// File: rtl/sync_shift_cmp.sv
// W-bit serial shift register with saturating fill counter, exposing the
// window ending at the current bit and its compares against the two key words.
module sync_shift_cmp
   import fsync_pkg::*;
#(
   parameter int unsigned    W            = 5,
   parameter logic [W-1:0]   SECUENCIA    = SECUENCIA_DEF,
   parameter logic [W-1:0]   SEC_REINICIO = SEC_REINICIO_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         s_in,
   input  logic         clr_fill,
   output logic [W-1:0] win,
   output logic         fill_ok,
   output logic         match_sync,
   output logic         match_reinicio
);

   localparam int unsigned FW = $clog2(W + 1);

   logic [W-1:0]  sr_q, sr_d;
   logic [FW-1:0] fill_q, fill_d;

   assign win            = {sr_q[W-2:0], s_in};
   assign fill_ok        = (fill_q >= FW'(W - 1));
   assign match_sync     = (win == SECUENCIA);
   assign match_reinicio = (win == SEC_REINICIO);

   // Clearing fill on loss of lock makes stale register content unusable for relock.
   always_comb begin
      sr_d   = sr_q;
      fill_d = fill_q;
      if (en) begin
         sr_d = win;
         if (clr_fill) begin
            fill_d = '0;
         end else if (fill_q != FW'(W)) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q   <= '0;
         fill_q <= '0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-sync controller: hunts for the sync word, then slices the serial
// stream into W-bit words until LOSS_N consecutive loss-of-sync words arrive.
module frame_sync_ctrl
   import fsync_pkg::*;
#(
   parameter int unsigned    W            = 5,
   parameter logic [W-1:0]   SECUENCIA    = SECUENCIA_DEF,
   parameter logic [W-1:0]   SEC_REINICIO = SEC_REINICIO_DEF,
   parameter int unsigned    LOSS_N       = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            s_in,
   output logic                            valido,
   output logic [W-1:0]                    word_out,
   output logic                            word_valid,
   output logic                            sync_lost,
   output logic [$clog2(LOSS_N+1)-1:0]     bad_cnt
);

   localparam int unsigned CW = $clog2(W);
   localparam int unsigned BW = $clog2(LOSS_N + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(W - 1);
   localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_N - 1);

   fsync_state_e  state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] bad_cnt_q, bad_cnt_d;
   logic [W-1:0]  word_q, word_d;
   logic          valido_q, valido_d;
   logic          word_valid_q, word_valid_d;
   logic          sync_lost_q, sync_lost_d;

   logic [W-1:0]  win;
   logic          fill_ok;
   logic          match_sync;
   logic          match_reinicio;
   logic          clr_fill;

   sync_shift_cmp #(
      .W            (W),
      .SECUENCIA    (SECUENCIA),
      .SEC_REINICIO (SEC_REINICIO)
   ) u_shift (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .s_in           (s_in),
      .clr_fill       (clr_fill),
      .win            (win),
      .fill_ok        (fill_ok),
      .match_sync     (match_sync),
      .match_reinicio (match_reinicio)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      bad_cnt_d    = bad_cnt_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      sync_lost_d  = 1'b0;
      clr_fill     = 1'b0;

      if (en) begin
         unique case (state_q)
            ST_HUNT: begin
               if (fill_ok && match_sync) begin
                  state_d   = ST_SYNCED;
                  bit_cnt_d = '0;
                  bad_cnt_d = '0;
               end
            end
            ST_SYNCED: begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  if (!match_reinicio) begin
                     word_d       = win;
                     word_valid_d = 1'b1;
                     bad_cnt_d    = '0;
                  end else if (bad_cnt_q != LOSS_LAST) begin
                     bad_cnt_d = bad_cnt_q + 1'b1;
                  end else begin
                     state_d     = ST_HUNT;
                     sync_lost_d = 1'b1;
                     bad_cnt_d   = '0;
                     clr_fill    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      valido_d = (state_d == ST_SYNCED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_HUNT;
         bit_cnt_q    <= '0;
         bad_cnt_q    <= '0;
         word_q       <= '0;
         valido_q     <= 1'b0;
         word_valid_q <= 1'b0;
         sync_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         word_q       <= word_d;
         valido_q     <= valido_d;
         word_valid_q <= word_valid_d;
         sync_lost_q  <= sync_lost_d;
      end
   end

   assign valido     = valido_q;
   assign word_out   = word_q;
   assign word_valid = word_valid_q;
   assign sync_lost  = sync_lost_q;
   assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: two instances (LOSS_N=1 and LOSS_N=2) share one
// stimulus stream and are compared every cycle against a bit-queue reference model.
module tb_frame_sync_ctrl;
   import fsync_pkg::*;

   localparam int W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic s_in = 1'b0;

   logic         valido0, word_valid0, sync_lost0, bad0;
   logic [W-1:0] word0;
   logic         valido1, word_valid1, sync_lost1;
   logic [1:0]   bad1;
   logic [W-1:0] word1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   frame_sync_ctrl #(
      .W            (W),
      .SECUENCIA    (SECUENCIA_DEF),
      .SEC_REINICIO (SEC_REINICIO_DEF),
      .LOSS_N       (1)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .s_in       (s_in),
      .valido     (valido0),
      .word_out   (word0),
      .word_valid (word_valid0),
      .sync_lost  (sync_lost0),
      .bad_cnt    (bad0)
   );

   frame_sync_ctrl #(
      .W            (W),
      .SECUENCIA    (SECUENCIA_DEF),
      .SEC_REINICIO (SEC_REINICIO_DEF),
      .LOSS_N       (2)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .s_in       (s_in),
      .valido     (valido1),
      .word_out   (word1),
      .word_valid (word_valid1),
      .sync_lost  (sync_lost1),
      .bad_cnt    (bad1)
   );

   // Reference model: per instance, the fresh bits seen while hunting and the
   // bits collected for the current word while locked.
   int loss_n [2] = '{1, 2};
   int m_sync [2];
   int m_fresh[2];
   int m_hacc [2];
   int m_nb   [2];
   int m_wacc [2];
   int m_bad  [2];
   int m_word [2];
   int m_wv   [2];
   int m_lost [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_sync[i] = 0; m_fresh[i] = 0; m_hacc[i] = 0; m_nb[i] = 0;
         m_wacc[i] = 0; m_bad[i] = 0; m_word[i] = 0; m_wv[i] = 0; m_lost[i] = 0;
      end
   endtask

   task automatic m_step(input int i, input bit e, input bit b);
      m_wv[i]   = 0;
      m_lost[i] = 0;
      if (e) begin
         if (m_sync[i] == 0) begin
            m_hacc[i] = ((m_hacc[i] << 1) | int'(b)) % 32;
            if (m_fresh[i] < W) m_fresh[i]++;
            if (m_fresh[i] >= W && m_hacc[i] == int'(SECUENCIA_DEF)) begin
               m_sync[i] = 1; m_nb[i] = 0; m_wacc[i] = 0; m_bad[i] = 0;
            end
         end else begin
            m_wacc[i] = m_wacc[i] * 2 + int'(b);
            m_nb[i]++;
            if (m_nb[i] == W) begin
               if (m_wacc[i] != int'(SEC_REINICIO_DEF)) begin
                  m_word[i] = m_wacc[i]; m_wv[i] = 1; m_bad[i] = 0;
               end else begin
                  m_bad[i]++;
                  if (m_bad[i] == loss_n[i]) begin
                     m_sync[i] = 0; m_lost[i] = 1; m_bad[i] = 0; m_fresh[i] = 0;
                  end
               end
               m_nb[i] = 0; m_wacc[i] = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("valido0",     valido0,     m_sync[0]);
      chk("word_valid0", word_valid0, m_wv[0]);
      chk("word_out0",   word0,       m_word[0]);
      chk("sync_lost0",  sync_lost0,  m_lost[0]);
      chk("bad_cnt0",    bad0,        m_bad[0]);
      chk("valido1",     valido1,     m_sync[1]);
      chk("word_valid1", word_valid1, m_wv[1]);
      chk("word_out1",   word1,       m_word[1]);
      chk("sync_lost1",  sync_lost1,  m_lost[1]);
      chk("bad_cnt1",    bad1,        m_bad[1]);
   endtask

   task automatic step(input bit e, input bit b);
      @(negedge clk);
      en   = e;
      s_in = b;
      @(posedge clk);
      m_step(0, e, b);
      m_step(1, e, b);
      #1 check_all();
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int k = W - 1; k >= 0; k--) step(1'b1, w[k]);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      m_reset();
      #1 check_all();
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] w;
      int sel;
      m_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;

      send_word(5'b11011);
      chk("nolock", valido0, 1'b0);
      send_word(5'b10100);
      chk("lock0", valido0, 1'b1);
      chk("lock1", valido1, 1'b1);
      chk("nolost", sync_lost0, 1'b0);
      send_word(5'b11001);
      chk("wv_first", word_valid0, 1'b1);
      chk("wo_first", word0, 5'b11001);
      send_word(5'b00000);
      chk("lost0", sync_lost0, 1'b1);
      chk("drop0", valido0, 1'b0);
      chk("wo_keep0", word0, 5'b11001);
      chk("bad1_one", bad1, 2'd1);
      chk("hold1", valido1, 1'b1);
      send_word(5'b01110);
      chk("wo1_data", word1, 5'b01110);
      chk("bad1_clr", bad1, 2'd0);
      send_word(5'b00000);
      chk("bad1_again", bad1, 2'd1);
      send_word(5'b00000);
      chk("lost1", sync_lost1, 1'b1);
      chk("drop1", valido1, 1'b0);

      send_word(5'b10100);
      chk("relock0", valido0, 1'b1);
      chk("relock1", valido1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("pause_wv", word_valid0, 1'b1);
      chk("pause_wo", word0, 5'b10110);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      async_reset();
      chk("rst_valido", valido0, 1'b0);
      chk("rst_word", word0, 5'b00000);
      send_word(5'b10100);
      chk("rst_relock", valido0, 1'b1);

      for (int c = 0; c < 400; c++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3)      w = SECUENCIA_DEF;
         else if (sel < 6) w = SEC_REINICIO_DEF;
         else              w = W'($urandom);
         for (int k = W - 1; k >= 0; k--) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom));
            step(1'b1, w[k]);
         end
         if ($urandom_range(0, 60) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
- Serial frame-synchronization controller for the 1-bit `s_in` stream feeding the sequence-detector datapath.
- HUNT mode: searches bit-by-bit for the sync word `SECUENCIA`.
- On lock, slices the stream into W-bit words and emits them with a strobe.
- Drops lock after `LOSS_N` consecutive words equal to `SEC_REINICIO`, then returns to HUNT.
- Drives the system-level `valido` lock indicator.

Parameters:
- W, 5, word and sync-field width in bits (≥2).
- SECUENCIA, 5'b10100, sync word; W bits, MSB received first.
- SEC_REINICIO, 5'b00000, loss-of-sync word; W bits; must differ from SECUENCIA.
- LOSS_N, 1, consecutive SEC_REINICIO words required to drop lock (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  bit-enable; s_in is sampled only on edges with en=1.
- s_in  in  1  serial data, MSB of each word first.
- valido  out  1  level; 1 while in SYNCED.
- word_out  out  W  last accepted data word; holds between strobes.
- word_valid  out  1  one-cycle strobe; word_out updated this cycle.
- sync_lost  out  1  one-cycle strobe on the SYNCED→HUNT transition.
- bad_cnt  out  clog2(LOSS_N+1)  current consecutive SEC_REINICIO count (debug).

Behaviour:
- Reset (rst=0, async):
  - state=HUNT.
  - Shift register, fill counter, bit counter and bad_cnt cleared to 0.
  - valido=0, word_out=0, word_valid=0, sync_lost=0.
- All outputs are registered.
- win = {sr[W-2:0], s_in}, the W-bit window ending at the current bit.
- On each edge with en=1: sr <= win. With en=0, all state holds and the strobes clear to 0.
- HUNT:
  - Fill counter counts accepted bits, saturating at W.
  - Match is legal only when fill ≥ W-1 (at least W fresh bits including the current one).
  - On match (win==SECUENCIA):
    - Go to SYNCED; valido=1 from that edge.
    - Bit counter=0, bad_cnt=0.
  - No overlap carry-over: the sync word's bits are never reused as data.
- SYNCED:
  - Bit counter increments per accepted bit, 0..W-1, then wraps to 0.
  - At count==W-1 the word completes (evaluate win).
  - win≠SEC_REINICIO:
    - word_out<=win, word_valid=1 for one cycle.
    - bad_cnt<=0.
    - A data word equal to SECUENCIA is ordinary data.
  - win==SEC_REINICIO and bad_cnt+1<LOSS_N:
    - bad_cnt++; word not emitted; stay SYNCED.
  - win==SEC_REINICIO and bad_cnt+1==LOSS_N:
    - Go to HUNT; valido=0 and sync_lost=1 on the same edge.
    - bad_cnt=0, fill=0; word not emitted.
- Re-entry to HUNT clears fill, so a new lock needs ≥W new bits; stale shift-register content can never relock.
- Latency:
  - valido rises on the edge sampling the last sync bit.
  - word_valid rises on the edge sampling bit W-1 of each word.
- en deasserted mid-word: the bit counter pauses and the word resumes on the next accepted bit. No timeout.
- rst asserted mid-word or mid-lock: immediate return to reset values; no strobe is emitted.
- Counter widths: bit counter clog2(W); bad counter clog2(LOSS_N+1). No arithmetic overflow is possible.

Decomposition:
- Package fsync_pkg:
  - State encoding localparams ST_HUNT=1'b0, ST_SYNCED=1'b1.
  - Default SECUENCIA / SEC_REINICIO constants, shared with the testbench probe.
- One sub-module, sync_shift_cmp:
  - Contains the W-bit shift register with enable, the fill counter, and the combinational win output.
  - Also provides two compare flags (match_sync, match_reinicio).
- The FSM, counters and output registers stay in frame_sync_ctrl.

Test Plan:
- Reset then bits 11011 → no lock; valido=0 and word_valid=0 throughout; fill saturates at W.
- Continue with 10100 → valido=1 on the 10th accepted edge; sync_lost=0.
- Continue with 11001 → word_valid=1 for one cycle on the 15th edge; word_out=5'b11001, held afterwards; valido stays 1.
- Continue with 00000, LOSS_N=1 → on the 20th edge sync_lost=1 (one cycle) and valido=0; word_valid stays 0; word_out remains 5'b11001.
- LOSS_N=2: lock, then 00000, 01110, 00000, 00000 → first bad word gives bad_cnt=1; 01110 is emitted and resets bad_cnt=0; lock drops only after the second consecutive 00000.
- Lock, then toggle en=0 for 3 cycles mid-word with s_in toggling, then assert rst=0 mid-word → enabled bits only form the word, and the word is correct after resume; on reset, all outputs are 0 asynchronously, and after release 10100 is required to relock.
